// File: rtl/ask_pkg.sv
// ask_pkg: shared FSM state type and default frame/bit/carrier timing constants
package ask_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WORD_W       = 12;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_CARRIER_HALF = 2;
endpackage

// File: rtl/ask_carrier_gen.sv
// ask_carrier_gen: free-running carrier divider, toggles every CARRIER_HALF clocks
// Ports: clk (rising edge), rst (sync active-high, carrier=0), carrier (square wave, starts low)
module ask_carrier_gen #(
  parameter int CARRIER_HALF = ask_pkg::DEF_CARRIER_HALF
) (
  input  logic clk,
  input  logic rst,
  output logic carrier
);
  localparam int CW = CARRIER_HALF > 1 ? $clog2(CARRIER_HALF) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carrier_q, carrier_d, wrap;
  assign wrap = cnt_q == CW'(CARRIER_HALF - 1);
  always_comb begin
    cnt_d     = wrap ? '0 : cnt_q + CW'(1);
    carrier_d = carrier_q ^ wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      carrier_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      carrier_q <= carrier_d;
    end
  end
  assign carrier = carrier_q;
endmodule

// File: rtl/ask_tx_serializer.sv
// ask_tx_serializer: LSB-first frame serializer with on-off keyed carrier output
// Ports: clk, rst (sync active-high), word/newres (frame in + strobe), ready/busy (FSM status),
//        txbit (baseband), ask_out (txbit AND carrier), done (last frame cycle), overrun (sticky),
//        frame_err (reject pulse).
// Option: define ASK_FRAME_CHECK_EN to reject frames with a bad start/stop bit; otherwise frame_err=0.
module ask_tx_serializer import ask_pkg::*; #(
  parameter int WORD_W       = DEF_WORD_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CARRIER_HALF = DEF_CARRIER_HALF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word,
  input  logic              newres,
  output logic              ready,
  output logic              busy,
  output logic              txbit,
  output logic              ask_out,
  output logic              done,
  output logic              overrun,
  output logic              frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WORD_W-2:0] sh_q, sh_d;
  logic txbit_q, txbit_d, overrun_q, overrun_d, carrier;
  logic shifting, accept, reject, bit_end, last;
  ask_carrier_gen #(.CARRIER_HALF(CARRIER_HALF)) u_carrier (
    .clk     (clk),
    .rst     (rst),
    .carrier (carrier)
  );
`ifdef ASK_FRAME_CHECK_EN
  logic frame_err_q;
  assign reject = newres && (word[0] || !word[WORD_W-1]);
  always_ff @(posedge clk) frame_err_q <= rst ? 1'b0 : (state_q == IDLE) && reject;
  assign frame_err = frame_err_q;
`else
  assign reject    = 1'b0;
  assign frame_err = 1'b0;
`endif
  assign shifting = state_q == SHIFT;
  assign accept   = newres && !shifting && !reject;
  assign bit_end  = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign last     = shifting && bit_end && idx_q == IW'(WORD_W - 1);
  // word[0] goes straight to txbit; the shift register holds only the bits still to send
  always_comb begin
    state_d   = accept ? SHIFT : last ? IDLE : state_q;
    cnt_d     = (shifting && !bit_end) ? cnt_q + CW'(1) : '0;
    idx_d     = !shifting ? '0 : bit_end ? idx_q + IW'(1) : idx_q;
    sh_d      = accept ? word[WORD_W-1:1] : (shifting && bit_end) ? sh_q >> 1 : sh_q;
    txbit_d   = accept ? word[0] : (!shifting || last) ? 1'b1 : bit_end ? sh_q[0] : txbit_q;
    overrun_d = overrun_q || (newres && shifting);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      txbit_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      txbit_q   <= txbit_d;
      overrun_q <= overrun_d;
    end
  end
  assign ready   = !shifting;
  assign busy    = shifting;
  assign txbit   = txbit_q;
  assign done    = last;
  assign overrun = overrun_q;
  assign ask_out = txbit_q & carrier;
endmodule

// File: doc/ask_tx_serializer.md
ASK_TX_SERIALIZER -- requirements
Module: ask_tx_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 12, the frame width in bits: start bit, payload, stop bit.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, the clocks each bit is held (>=2).
REQ-003 SHALL have parameter CARRIER_HALF, default 2, the clocks per carrier half-period (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port word  input  WORD_W  frame to send; LSB is the start bit, MSB is the stop bit.
REQ-007 SHALL have port newres  input  1  one-cycle strobe: word valid this cycle.
REQ-008 SHALL have port ready  output  1  high when a newres is accepted this cycle.
REQ-009 SHALL have port busy  output  1  high while a frame is shifting.
REQ-010 SHALL have port txbit  output  1  current baseband bit.
REQ-011 SHALL have port ask_out  output  1  modulated output, equal to txbit AND carrier.
REQ-012 SHALL have port done  output  1  one-cycle pulse in the last cycle of a frame.
REQ-013 SHALL have port overrun  output  1  sticky flag: newres arrived while not ready.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on a rejected frame (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE and SHIFT.
REQ-016 SHALL hold ready=1, busy=0 and txbit=1 (mark) in IDLE.
REQ-017 SHALL, on newres=1 in IDLE (cycle N), latch word into a shift register and enter SHIFT at N+1.
REQ-018 SHALL, in SHIFT, drive txbit = word[k] during cycles N+1+k*CLKS_PER_BIT .. N+(k+1)*CLKS_PER_BIT, k=0..WORD_W-1, LSB first.
REQ-019 SHALL use a bit-period counter 0..CLKS_PER_BIT-1 and a bit index 0..WORD_W-1, both cleared on frame accept.
REQ-020 SHALL pulse done in cycle N+WORD_W*CLKS_PER_BIT, and in that cycle return to IDLE at the next edge (ready=1 at N+WORD_W*CLKS_PER_BIT+1).
REQ-021 SHALL ignore newres while in SHIFT (word not latched, frame in flight unaffected) and set overrun=1 until reset.
REQ-022 SHALL run the carrier free-running regardless of state, toggling every CARRIER_HALF clocks.
REQ-023 SHALL derive ask_out combinationally from registered txbit and the carrier register, with no other logic.

Reset
REQ-024 SHALL, on rst=1 at any edge, enter IDLE and set ready=1, busy=0, txbit=1, done=0, overrun=0, frame_err=0, carrier=0, and clear all counters.
REQ-025 SHALL abort any frame in progress on mid-frame reset, with no done pulse.
REQ-026 SHALL give rst priority over newres in the same cycle.

Configuration
REQ-027 SHALL, with ASK_FRAME_CHECK_EN defined, reject a newres in IDLE whose word[0]!=0 or word[WORD_W-1]!=1: stay in IDLE, no latch, frame_err=1 for one cycle.
REQ-028 SHALL, without ASK_FRAME_CHECK_EN, accept all frames unchecked and tie frame_err to constant 0.

Structure
REQ-029 SHALL place the state enum and the default WORD_W/CLKS_PER_BIT/CARRIER_HALF constants in shared package ask_pkg.
REQ-030 SHALL instantiate the carrier divider as sub-module ask_carrier_gen (ports clk, rst, carrier; parameter CARRIER_HALF).

Verification
REQ-031 SHALL cover: CLKS_PER_BIT=4, word=12'h802, newres at N -> txbit 0 for N+1..N+4, 1 for N+5..N+8, 0 for N+9..N+44, 1 for N+45..N+48; done at N+48; ready=1 at N+49.
REQ-032 SHALL cover: CARRIER_HALF=2, idle after reset -> carrier 0,0,1,1,0,0,... and ask_out equal to carrier.
REQ-033 SHALL cover: second newres at N+10 during a frame -> overrun=1 from N+11, first frame bits unchanged, no second frame.
REQ-034 SHALL cover: rst at N+20 mid-frame -> next cycle txbit=1, ready=1, busy=0, overrun=0; no done pulse.
REQ-035 SHALL cover, with ASK_FRAME_CHECK_EN: word=12'h803 -> frame_err pulse at N+1, ready stays 1, txbit stays 1; without the macro, the same frame is shifted out.
REQ-036 SHALL cover: back-to-back frames with newres at N+49 after done at N+48 -> accepted, txbit=0 at N+50.
